// File: rtl/instr_fetch.sv
// Instruction fetch stage: req/gnt/rvalid memory port, PC update and a small instruction FIFO for decode.
// Define FETCH_BYPASS_EN to hand a response straight to decode when the FIFO is empty.
module instr_fetch #(
    parameter int XLEN       = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [XLEN-1:0] pc_curr_i,
    output logic [XLEN-1:0] pc_next_o,
    output logic            pc_write_o,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [31:0]     imem_rdata_i,
    output logic            instr_valid_o,
    output logic [31:0]     instr_o,
    output logic [XLEN-1:0] instr_pc_o,
    input  logic            instr_ready_i
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        S_BOOT,
        S_IDLE,
        S_REQ,
        S_WAIT
    } state_t;

    state_t          state;
    logic [XLEN-1:0] addr_q;
    logic            drop_q;

    logic [31:0]     fifo_instr [FIFO_DEPTH];
    logic [XLEN-1:0] fifo_pc    [FIFO_DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;

    logic            resp;
    logic            resp_keep;
    logic            space;
    logic            issue_ok;
    logic            gnt_fire;
    logic            bypass;
    logic            push;
    logic            pop;
    logic            fifo_valid;
    logic [XLEN-1:0] aligned_pc;
    logic            unused_low_bits;

    assign unused_low_bits = ^{pc_curr_i[1:0], redirect_pc_i[1:0]};
    assign aligned_pc      = {pc_curr_i[XLEN-1:2], 2'b00};

    // Only a response to the outstanding transaction counts; pops are deliberately ignored for space.
    assign resp      = (state == S_WAIT) && imem_rvalid_i;
    assign resp_keep = resp && !drop_q;
    assign space     = ((CW+1)'(count) + (CW+1)'(resp_keep)) < (CW+1)'(FIFO_DEPTH);
    assign issue_ok  = ((state == S_IDLE) || resp) && space && !redirect_i;

    assign imem_req_o  = issue_ok || (state == S_REQ);
    assign imem_addr_o = (state == S_REQ) ? addr_q : (issue_ok ? aligned_pc : '0);
    assign gnt_fire    = imem_req_o && imem_gnt_i;

    assign pc_write_o = (state != S_BOOT) && (redirect_i || gnt_fire);

    always_comb begin
        pc_next_o = '0;
        if (state != S_BOOT) begin
            if (redirect_i) begin
                pc_next_o = {redirect_pc_i[XLEN-1:2], 2'b00};
            end else if (gnt_fire) begin
                pc_next_o = imem_addr_o + XLEN'(4);
            end
        end
    end

`ifdef FETCH_BYPASS_EN
    assign bypass = resp_keep && !redirect_i && (count == '0) && instr_ready_i;
`else
    assign bypass = 1'b0;
`endif

    assign fifo_valid = (count != '0);
    assign push       = resp_keep && !redirect_i && !bypass;
    assign pop        = fifo_valid && instr_ready_i && !redirect_i;

    assign instr_valid_o = fifo_valid || bypass;

    always_comb begin
        instr_o    = '0;
        instr_pc_o = '0;
        if (fifo_valid) begin
            instr_o    = fifo_instr[rd_ptr];
            instr_pc_o = fifo_pc[rd_ptr];
        end else if (bypass) begin
            instr_o    = imem_rdata_i;
            instr_pc_o = addr_q;
        end
    end

    // Fetch FSM; a redirect marks any pending or just-granted transaction so its response is dropped.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state  <= S_BOOT;
            addr_q <= '0;
            drop_q <= 1'b0;
        end else begin
            if (issue_ok) begin
                addr_q <= aligned_pc;
            end

            if (redirect_i && ((state == S_REQ) || ((state == S_WAIT) && !imem_rvalid_i))) begin
                drop_q <= 1'b1;
            end else if (resp) begin
                drop_q <= 1'b0;
            end

            case (state)
                S_BOOT: state <= S_IDLE;
                S_IDLE: begin
                    if (gnt_fire) begin
                        state <= S_WAIT;
                    end else if (imem_req_o) begin
                        state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (gnt_fire) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (resp) begin
                        if (gnt_fire) begin
                            state <= S_WAIT;
                        end else if (imem_req_o) begin
                            state <= S_REQ;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_BOOT;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    // Storage needs no reset: the read side is gated by the entry count.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_instr[wr_ptr] <= imem_rdata_i;
            fifo_pc[wr_ptr]    <= addr_q;
        end
    end

    assert property (@(posedge clk_i) disable iff (!rst_ni) !(push && (count == CW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: a PC register and memory model drive the DUT, a monitor checks delivered instructions.
// Build with FETCH_BYPASS_EN defined to check the zero-latency path.
module tb_instr_fetch;

    localparam int          XLEN  = 32;
    localparam int          DEPTH = 2;
    localparam logic [31:0] BASE  = 32'h4000_0000;
`ifdef FETCH_BYPASS_EN
    localparam logic        BYP = 1'b1;
`else
    localparam logic        BYP = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic [XLEN-1:0] pc_curr;
    logic [XLEN-1:0] pc_next;
    logic            pc_write;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [31:0]     imem_rdata;
    logic            instr_valid;
    logic [31:0]     instr;
    logic [XLEN-1:0] instr_pc;
    logic            instr_ready;

    int              vec_cnt   = 0;
    int              miscompare = 0;
    int              delivered = 0;
    int              lat       = 1;
    logic [31:0]     exp_q[$];

    instr_fetch #(.XLEN(XLEN), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .pc_curr_i    (pc_curr),
        .pc_next_o    (pc_next),
        .pc_write_o   (pc_write),
        .redirect_i   (redirect),
        .redirect_pc_i(redirect_pc),
        .imem_req_o   (imem_req),
        .imem_addr_o  (imem_addr),
        .imem_gnt_i   (imem_gnt),
        .imem_rvalid_i(imem_rvalid),
        .imem_rdata_i (imem_rdata),
        .instr_valid_o(instr_valid),
        .instr_o      (instr),
        .instr_pc_o   (instr_pc),
        .instr_ready_i(instr_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] sig(input logic [31:0] a);
        return {a[15:0], a[31:16] ^ 16'hBEEF};
    endfunction

    task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] want);
        vec_cnt++;
        if (got !== want) begin
            miscompare++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, got, want, $time);
        end
    endtask

    task automatic push_stream(input logic [31:0] start);
        exp_q.delete();
        for (int i = 0; i < 64; i++) begin
            exp_q.push_back(start + 32'(4 * i));
        end
    endtask

    task automatic wait_fire();
        bit found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            found = imem_req && imem_gnt;
        end
        if (!found) begin
            check_output("grant_timeout", 32'd0, 32'd1);
        end
    endtask

    task automatic apply_stimulus(input logic gnt, input logic rdy);
        @(posedge clk);
        #2;
        imem_gnt    = gnt;
        instr_ready = rdy;
    endtask

    // Upstream PC register plus a single-outstanding memory with configurable grant-to-response latency.
    logic        fire;
    logic        pend = 1'b0;
    logic [31:0] faddr;
    logic [31:0] paddr;
    logic        w_pc;
    logic [31:0] n_pc;
    int          cnt;
    always begin
        @(negedge clk);
        fire  = rst_n && imem_req && imem_gnt;
        faddr = imem_addr;
        w_pc  = pc_write;
        n_pc  = pc_next;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            pc_curr = BASE;
        end else if (w_pc) begin
            pc_curr = n_pc;
        end
        imem_rvalid = 1'b0;
        if (fire) begin
            pend  = 1'b1;
            paddr = faddr;
            cnt   = lat;
        end
        if (pend) begin
            if (cnt <= 1) begin
                imem_rvalid = 1'b1;
                imem_rdata  = sig(paddr);
                pend        = 1'b0;
            end else begin
                cnt--;
            end
        end
    end

    // Monitor: every accepted instruction must match the head of the expected stream.
    always @(negedge clk) begin
        if (rst_n && instr_valid && instr_ready && !redirect) begin
            if (exp_q.size() == 0) begin
                check_output("unexpected_instr", instr_pc, 32'hFFFF_FFFF);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                check_output("deliver_pc", instr_pc, e);
                check_output("deliver_instr", instr, sig(e));
                delivered++;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int d0;
        rst_n       = 1'b0;
        pc_curr     = BASE;
        redirect    = 1'b0;
        redirect_pc = '0;
        imem_gnt    = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        instr_ready = 1'b1;
        push_stream(BASE);

        repeat (2) @(negedge clk);
        check_output("rst_req", 32'(imem_req), 32'd0);
        check_output("rst_addr", imem_addr, 32'd0);
        check_output("rst_pc_write", 32'(pc_write), 32'd0);
        check_output("rst_pc_next", pc_next, 32'd0);
        check_output("rst_valid", 32'(instr_valid), 32'd0);
        check_output("rst_instr", instr, 32'd0);
        check_output("rst_instr_pc", instr_pc, 32'd0);

        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check_output("boot_req", 32'(imem_req), 32'd0);
        check_output("boot_pc_write", 32'(pc_write), 32'd0);
        @(negedge clk);
        check_output("first_req", 32'(imem_req), 32'd1);
        check_output("first_addr", imem_addr, 32'h4000_0000);
        check_output("first_pc_write", 32'(pc_write), 32'd1);
        check_output("first_pc_next", pc_next, 32'h4000_0004);
        repeat (20) @(negedge clk);
        @(posedge clk);
        #2;
        check_output("stream_progress", 32'(delivered >= 8), 32'd1);

        instr_ready = 1'b0;
        repeat (10) @(negedge clk);
        check_output("bp_req", 32'(imem_req), 32'd0);
        check_output("bp_pc_write", 32'(pc_write), 32'd0);
        check_output("bp_valid", 32'(instr_valid), 32'd1);
        check_output("bp_head_pc", instr_pc, exp_q[0]);

        apply_stimulus(1'b0, 1'b1);
        d0 = delivered;
        repeat (6) @(negedge clk);
        @(posedge clk);
        #2;
        check_output("bp_drain_count", 32'(delivered - d0), 32'(DEPTH));

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_output("stall_req", 32'(imem_req), 32'd1);
            check_output("stall_addr", imem_addr, exp_q[0]);
            check_output("stall_pc_write", 32'(pc_write), 32'd0);
        end

        apply_stimulus(1'b1, 1'b1);
        @(negedge clk);
        check_output("gnt_pc_write", 32'(pc_write), 32'd1);
        check_output("gnt_pc_next", pc_next, exp_q[0] + 32'd4);
        @(negedge clk);
        check_output("resp_cycle_valid", 32'(instr_valid), 32'(BYP));
        @(negedge clk);
        check_output("resp_next_valid", 32'(instr_valid), 32'd1);

        @(posedge clk);
        #2 lat = 3;
        wait_fire();
        @(posedge clk);
        #2;
        redirect    = 1'b1;
        redirect_pc = 32'h4000_0103;
        push_stream(32'h4000_0100);
        @(negedge clk);
        check_output("rdw_pc_write", 32'(pc_write), 32'd1);
        check_output("rdw_pc_next", pc_next, 32'h4000_0100);
        check_output("rdw_req", 32'(imem_req), 32'd0);
        @(posedge clk);
        #2;
        redirect = 1'b0;
        lat      = 1;
        d0       = delivered;
        @(negedge clk);
        check_output("rdw_flushed", 32'(instr_valid), 32'd0);
        repeat (15) @(negedge clk);
        @(posedge clk);
        #2;
        check_output("rdw_progress", 32'(delivered - d0 >= 3), 32'd1);

        wait_fire();
        @(posedge clk);
        #2;
        redirect    = 1'b1;
        redirect_pc = 32'h4000_0200;
        push_stream(32'h4000_0200);
        @(negedge clk);
        check_output("rdv_pc_next", pc_next, 32'h4000_0200);
        check_output("rdv_pc_write", 32'(pc_write), 32'd1);
        check_output("rdv_req", 32'(imem_req), 32'd0);
        @(posedge clk);
        #2 redirect = 1'b0;
        @(negedge clk);
        check_output("rdv_flushed", 32'(instr_valid), 32'd0);
        check_output("rdv_next_addr", imem_addr, 32'h4000_0200);
        repeat (10) @(negedge clk);

        apply_stimulus(1'b0, 1'b1);
        repeat (4) @(negedge clk);
        check_output("rdg_req_held", 32'(imem_req), 32'd1);
        @(posedge clk);
        #2;
        imem_gnt    = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h4000_0300;
        push_stream(32'h4000_0300);
        @(negedge clk);
        check_output("rdg_pc_next", pc_next, 32'h4000_0300);
        check_output("rdg_pc_write", 32'(pc_write), 32'd1);
        check_output("rdg_req", 32'(imem_req), 32'd1);
        @(posedge clk);
        #2 redirect = 1'b0;
        d0 = delivered;
        repeat (12) @(negedge clk);
        @(posedge clk);
        #2;
        check_output("rdg_progress", 32'(delivered - d0 >= 3), 32'd1);

        lat = 2;
        wait_fire();
        @(posedge clk);
        #2;
        rst_n   = 1'b0;
        pc_curr = BASE;
        lat     = 1;
        push_stream(BASE);
        #1;
        check_output("arst_req", 32'(imem_req), 32'd0);
        check_output("arst_valid", 32'(instr_valid), 32'd0);
        check_output("arst_pc_write", 32'(pc_write), 32'd0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_output("arst_boot_req", 32'(imem_req), 32'd0);
        @(negedge clk);
        check_output("arst_restart_addr", imem_addr, BASE);
        check_output("arst_late_valid", 32'(instr_valid), 32'd0);
        d0 = delivered;
        repeat (12) @(negedge clk);
        @(posedge clk);
        #2;
        check_output("arst_progress", 32'(delivered - d0 >= 3), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompare);
        $finish;
    end

endmodule
